// File: rtl/n_bit_piso_serializer.sv
// MSB-first parallel-in/serial-out serializer with a one-word holding register
// so consecutive words stream without an idle bit slot.
module n_bit_piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_en,
  output logic             o_serial,
  output logic             o_serial_valid,
  output logic             o_last,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic accept, fin;

  assign o_serial       = sreg_q[WIDTH-1];
  assign o_serial_valid = (state_q == SHIFT);
  assign o_last         = o_serial_valid & (cnt_q == LAST_CNT);
  assign o_ready        = !hold_full_q & !rst;
  assign o_busy         = (state_q == SHIFT) | hold_full_q;

  assign accept = i_valid & o_ready;
  assign fin    = o_last & i_en;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = i_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (fin) begin
          cnt_d = '0;
          // Held word has priority; a same-cycle accept can only happen when hold is empty.
          if (hold_full_q) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sreg_d = i_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (i_en) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
          end
          if (accept) begin
            hold_d      = i_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_n_bit_piso_serializer.sv
// Bench for n_bit_piso_serializer: directed bit-level scenarios plus a SIPO
// loopback scoreboard over random words.
module tb_n_bit_piso_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic         i_en;
  logic         o_serial;
  logic         o_serial_valid;
  logic         o_last;
  logic         o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] sipo;

  n_bit_piso_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_en(i_en), .o_serial(o_serial), .o_serial_valid(o_serial_valid),
    .o_last(o_last), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Accepted words go in the expected queue; the downstream SIPO completes a word on o_last consumption.
  always @(posedge clk) begin
    if (!rst) begin
      if (i_valid && o_ready) exp_q.push_back(i_data);
      if (o_serial_valid && i_en) begin
        sipo <= {sipo[W-2:0], o_serial};
        if (o_last) got_q.push_back({sipo[W-2:0], o_serial});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_clear();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_en = 1'b0; i_data = '0;
    tick(); tick();
    n_tests++;
    if ({o_serial, o_serial_valid, o_last, o_busy, o_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ser/sv/last/busy/rdy=%b expected 00000",
               {o_serial, o_serial_valid, o_last, o_busy, o_ready});
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_release: got %b expected 1", o_ready);
    end
    sb_clear();
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    w = 8'hA5;
    i_en = 1'b1; i_valid = 1'b1; i_data = w;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      n_tests++;
      if (o_serial !== w[W-1-i] || o_serial_valid !== 1'b1 || o_last !== (i == W-1)) begin
        n_fail++;
        $display("FAIL single_bit%0d: got ser=%b sv=%b last=%b expected ser=%b sv=1 last=%b",
                 i, o_serial, o_serial_valid, o_last, w[W-1-i], (i == W-1));
      end
      tick();
    end
    n_tests++;
    if (o_serial_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got sv=%b busy=%b expected 0 0", o_serial_valid, o_busy);
    end
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== w) begin
      n_fail++;
      $display("FAIL single_sipo: got %0d words, first=%h expected 1 word %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00, w);
    end
    sb_clear();
  endtask

  task automatic test_stream_hold();
    logic [2*W-1:0] bits;
    bits = 16'h3CF0;
    i_en = 1'b1; i_valid = 1'b1; i_data = bits[15:8];
    tick();
    for (int i = 0; i < 2*W; i++) begin
      n_tests++;
      if (o_serial !== bits[2*W-1-i] || o_serial_valid !== 1'b1 ||
          o_last !== (i == W-1 || i == 2*W-1) || o_ready !== (i == 0 || i >= W)) begin
        n_fail++;
        $display("FAIL stream_hold_bit%0d: got ser=%b sv=%b last=%b rdy=%b expected ser=%b sv=1 last=%b rdy=%b",
                 i, o_serial, o_serial_valid, o_last, o_ready, bits[2*W-1-i],
                 (i == W-1 || i == 2*W-1), (i == 0 || i >= W));
      end
      if (i == 0) begin i_valid = 1'b1; i_data = bits[7:0]; end
      else i_valid = 1'b0;
      tick();
    end
    n_tests++;
    if (o_serial_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_hold_idle: got sv=%b busy=%b expected 0 0", o_serial_valid, o_busy);
    end
    sb_clear();
  endtask

  task automatic test_bypass();
    logic [2*W-1:0] bits;
    bits = 16'hFF81;
    i_en = 1'b1; i_valid = 1'b1; i_data = bits[15:8];
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 2*W; i++) begin
      n_tests++;
      if (o_serial !== bits[2*W-1-i] || o_serial_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bypass_bit%0d: got ser=%b sv=%b expected ser=%b sv=1",
                 i, o_serial, o_serial_valid, bits[2*W-1-i]);
      end
      if (i == W-1) begin
        n_tests++;
        if (o_ready !== 1'b1 || o_last !== 1'b1) begin
          n_fail++;
          $display("FAIL bypass_fin: got rdy=%b last=%b expected 1 1", o_ready, o_last);
        end
        i_valid = 1'b1; i_data = bits[7:0];
      end else begin
        i_valid = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (o_serial_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_idle: got sv=%b expected 0", o_serial_valid);
    end
    sb_clear();
  endtask

  task automatic test_en_toggle();
    logic [W-1:0] w;
    int k, p;
    w = 8'h96; k = 0; p = 0;
    i_en = 1'b1; i_valid = 1'b1; i_data = w;
    tick();
    i_valid = 1'b0;
    while (k < W && p < 40) begin
      i_en = (p % 3 == 0);
      n_tests++;
      if (o_serial !== w[W-1-k] || o_serial_valid !== 1'b1 || o_last !== (k == W-1)) begin
        n_fail++;
        $display("FAIL en_toggle_cyc%0d: got ser=%b sv=%b last=%b expected ser=%b sv=1 last=%b",
                 p, o_serial, o_serial_valid, o_last, w[W-1-k], (k == W-1));
      end
      tick();
      if (i_en) k++;
      p++;
    end
    n_tests++;
    if (k != W || o_serial_valid !== 1'b0 || got_q.size() != 1 || got_q[0] !== w) begin
      n_fail++;
      $display("FAIL en_toggle_done: got consumed=%0d sv=%b words=%0d expected %0d 0 1 (%h)",
               k, o_serial_valid, got_q.size(), W, w);
    end
    i_en = 1'b1;
    sb_clear();
  endtask

  task automatic test_reset_mid();
    i_en = 1'b1; i_valid = 1'b1; i_data = 8'hC3;
    tick();
    i_data = 8'h5A;
    tick();
    i_valid = 1'b0;
    tick(); tick();
    n_tests++;
    if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got busy=%b rdy=%b expected 1 0", o_busy, o_ready);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (o_serial_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got sv=%b busy=%b rdy=%b expected 0 0 0",
               o_serial_valid, o_busy, o_ready);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b expected 1", o_ready);
    end
    for (int i = 0; i < 2*W; i++) begin
      n_tests++;
      if (o_serial_valid !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_quiet%0d: got sv=%b busy=%b expected 0 0", i, o_serial_valid, o_busy);
      end
      tick();
    end
    sb_clear();
  endtask

  task automatic test_random_loopback();
    int sent, checked, cyc;
    logic pend;
    logic [W-1:0] e, g;
    sent = 0; checked = 0; cyc = 0; pend = 1'b0;
    i_valid = 1'b0;
    while (checked < 100 && cyc < 20000) begin
      if (!pend && sent < 100 && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        i_data = W'($urandom);
      end
      i_valid = pend;
      i_en = ($urandom_range(0, 9) < 7);
      if (pend && o_ready) begin pend = 1'b0; sent++; end
      tick();
      cyc++;
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL loopback_extra: got word %h expected none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_fail++;
            $display("FAIL loopback_word%0d: got %h expected %h", checked, g, e);
          end
        end
        checked++;
      end
    end
    i_valid = 1'b0;
    n_tests++;
    if (checked != 100 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL loopback_count: got %0d words (%0d pending) expected 100 (0)",
               checked, exp_q.size());
    end
    sb_clear();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream_hold();
    test_bypass();
    test_en_toggle();
    test_reset_mid();
    test_random_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/n_bit_piso_serializer.md
# n_bit_piso_serializer

Parallel-in/serial-out serializer that accepts WIDTH-bit words over a valid/ready handshake and emits them MSB first, one bit per enabled cycle. It sits directly upstream of the team's n-bit SIPO shift register. MSB-first order means that after WIDTH shifts the SIPO holds the original word unchanged. A one-word holding register allows back-to-back words to stream with no idle bit slot between them.

## Interface
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_data  input  WIDTH  parallel word to serialize.
- i_valid  input  1  i_data is valid this cycle.
- o_ready  output  1  serializer can accept a word this cycle.
- i_en  input  1  bit strobe; the current bit is consumed on a cycle where o_serial_valid & i_en.
- o_serial  output  1  current serial bit, MSB of the word first.
- o_serial_valid  output  1  o_serial carries a live data bit.
- o_last  output  1  current bit is bit 0, the last bit of the word.
- o_busy  output  1  the shifter or the holding register is occupied.

## Operation
- Internal state:
  - shift register sreg[WIDTH-1:0];
  - bit counter cnt, $clog2(WIDTH) bits wide, counting bits already consumed;
  - holding register hold[WIDTH-1:0] with flag hold_full;
  - FSM with states IDLE and SHIFT.
- Output equations:
  - o_serial = sreg[WIDTH-1].
  - o_serial_valid = (state == SHIFT).
  - o_last = o_serial_valid & (cnt == WIDTH-1).
  - o_ready = !hold_full & !rst.
  - o_busy = (state == SHIFT) | hold_full.
- An accept occurs when i_valid & o_ready.
- Define "fin" as o_last & i_en, meaning the final bit of the current word is consumed this cycle.
- IDLE behaviour:
  - On accept: sreg <= i_data, cnt <= 0, go to SHIFT.
  - hold is not used in IDLE.
- SHIFT behaviour, for a consumed bit that is not fin: sreg <= {sreg[WIDTH-2:0],1'b0}, cnt <= cnt+1.
- SHIFT behaviour, on fin (checked in this priority):
  - If hold_full: sreg <= hold, cnt <= 0, hold_full <= 0; stay in SHIFT.
  - Else, if an accept occurs in the same cycle: sreg <= i_data, cnt <= 0; stay in SHIFT. The word bypasses hold.
  - Else: go to IDLE; cnt <= 0.
- SHIFT behaviour, on an accept that is not simultaneous with fin: hold <= i_data, hold_full <= 1.
- When i_en = 0, sreg, cnt and the FSM state are frozen. Accepts into hold are still allowed.
- Words are emitted in acceptance order. A word is never dropped or duplicated.
- i_data is ignored on any cycle with no accept.

## Timing
- Reset (rst = 1 at a rising edge):
  - sreg = 0, cnt = 0, hold = 0, hold_full = 0, state = IDLE.
  - Resulting outputs: o_serial = 0, o_serial_valid = 0, o_last = 0, o_busy = 0.
  - o_ready = 0 while rst is high and 1 in the first cycle after rst falls.
- Reset mid-word: the partial word and any held word are discarded. No further bits are emitted.
- Latency: for a word accepted at edge N while IDLE, its MSB appears on o_serial with o_serial_valid = 1 in cycle N+1.
- With i_en held at 1, a word occupies exactly WIDTH cycles. o_last is high in the WIDTH-th cycle.
- Streaming: if the next word is already in hold, or is accepted in the fin cycle, its MSB follows in the cycle after fin, with no gap.
- o_ready drops the cycle after a word is captured into hold. It rises again the cycle after that word moves into sreg.
- The i_valid / i_data source must hold i_data stable until accept. The serializer places no requirement on i_valid in any other cycle.
- Downstream connection: the SIPO must shift only on o_serial_valid & i_en.

## Test plan
- Reset, then accept 8'hA5 with i_en = 1 -> o_serial = 1,0,1,0,0,1,0,1 on cycles N+1..N+8; o_last only on N+8; IDLE and o_busy = 0 at N+9.
- Accept 8'h3C and, while it is shifting, 8'hF0 (goes to hold, o_ready = 0) -> 16 contiguous valid bits 00111100 11110000, no gap; o_ready returns to 1 the cycle after the fin of 8'h3C.
- Present i_valid with 8'h81 exactly in the fin cycle of 8'hFF, with hold empty -> bypass load; bits 11111111 10000001 contiguous.
- i_en toggles 1,0,0,1,... during 8'h96 -> a bit is consumed only on cycles with i_en = 1; o_serial and cnt hold while i_en = 0; the full word 10010110 is still emitted.
- Assert rst after 3 bits of 8'hC3 with 8'h5A in hold -> next cycle o_serial_valid = 0, o_busy = 0, o_ready = 1 after rst drops; neither word resumes.
- Loopback into the SIPO enabled on o_serial_valid & i_en, 100 random words with random i_valid and i_en -> after each o_last consumption the SIPO output equals the accepted word, in order.
